// File: rtl/lamp_mode_ctrl.sv
// Wall-switch lamp controller: off-on flicks inside the wait window step through
// colour patterns; staying off past the window turns the lamp off.
module lamp_mode_ctrl #(
  parameter int unsigned                   NUM_MODES  = 3,
  parameter int unsigned                   LED_W      = 4,
  parameter logic [NUM_MODES*LED_W-1:0]    PATTERNS   = 12'hC63,
  parameter int unsigned                   TICK_DIV   = 5000,
  parameter int unsigned                   WAIT_TICKS = 10000,
  localparam int unsigned                  MODE_W     = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic              Sys_CLK,
  input  logic              Sys_RST,
  input  logic              sw_in,
  input  logic              mem_en,
  output logic [LED_W-1:0]  LED,
  output logic [MODE_W-1:0] mode_idx,
  output logic              lamp_on
);

  localparam int unsigned PRESC_W = $clog2(TICK_DIV);
  localparam int unsigned CNT_W   = $clog2(WAIT_TICKS + 1);

  localparam logic [PRESC_W-1:0] PrescLast = PRESC_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]   CntLast   = CNT_W'(WAIT_TICKS - 1);
  localparam logic [MODE_W-1:0]  ModeLast  = MODE_W'(NUM_MODES - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOn   = 2'd1,
    StWait = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                sw_q;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic [MODE_W-1:0]   last_q, last_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LED_W-1:0]    led_q, led_d;
  logic                on_q, on_d;

  logic rise, fall, tick, expire;
  logic [MODE_W-1:0] next_mode;

  function automatic logic [LED_W-1:0] pattern_of(input logic [MODE_W-1:0] idx);
    return PATTERNS[idx*LED_W +: LED_W];
  endfunction

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    last_d    = last_q;
    presc_d   = presc_q;
    cnt_d     = cnt_q;
    led_d     = '0;
    on_d      = 1'b0;
    next_mode = mode_q;
    rise      = sw_in & ~sw_q;
    fall      = ~sw_in & sw_q;
    tick      = (presc_q == PrescLast);
    expire    = tick && (cnt_q == CntLast);

    case (state_q)
      StIdle: begin
        if (rise) begin
          next_mode = mem_en ? last_q : '0;
          state_d   = StOn;
          mode_d    = next_mode;
          led_d     = pattern_of(next_mode);
          on_d      = 1'b1;
        end
      end
      StOn: begin
        if (fall) begin
          state_d = StWait;
          presc_d = '0;
          cnt_d   = '0;
        end else begin
          led_d = pattern_of(mode_q);
          on_d  = 1'b1;
        end
      end
      StWait: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick) begin
          cnt_d = cnt_q + 1'b1;
        end
        // A rise on the expiry edge still counts as a flick.
        if (rise) begin
          next_mode = (mode_q == ModeLast) ? '0 : mode_q + 1'b1;
          state_d   = StOn;
          mode_d    = next_mode;
          led_d     = pattern_of(next_mode);
          on_d      = 1'b1;
        end else if (expire) begin
          state_d = StIdle;
          last_d  = mode_q;
          presc_d = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge Sys_CLK) begin
    if (!Sys_RST) begin
      state_q <= StIdle;
      sw_q    <= 1'b0;
      mode_q  <= '0;
      last_q  <= '0;
      presc_q <= '0;
      cnt_q   <= '0;
      led_q   <= '0;
      on_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sw_q    <= sw_in;
      mode_q  <= mode_d;
      last_q  <= last_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      on_q    <= on_d;
    end
  end

  assign LED      = led_q;
  assign mode_idx = mode_q;
  assign lamp_on  = on_q;

endmodule

// File: tb/tb_lamp_mode_ctrl.sv
// Bench for lamp_mode_ctrl: directed vector table plus randomized switch activity
// checked against a window-timing reference model.
module tb_lamp_mode_ctrl;

  localparam int unsigned NUM_MODES  = 3;
  localparam int unsigned LED_W      = 4;
  localparam int unsigned TICK_DIV   = 4;
  localparam int unsigned WAIT_TICKS = 3;
  localparam int          WINDOW     = TICK_DIV * WAIT_TICKS;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sw_in = 1'b0;
  logic             mem_en = 1'b0;
  logic [LED_W-1:0] led;
  logic [1:0]       mode_idx;
  logic             lamp_on;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lamp_mode_ctrl #(
    .NUM_MODES  (NUM_MODES),
    .LED_W      (LED_W),
    .PATTERNS   (12'hC63),
    .TICK_DIV   (TICK_DIV),
    .WAIT_TICKS (WAIT_TICKS)
  ) dut (
    .Sys_CLK  (clk),
    .Sys_RST  (rst_n),
    .sw_in    (sw_in),
    .mem_en   (mem_en),
    .LED      (led),
    .mode_idx (mode_idx),
    .lamp_on  (lamp_on)
  );

  // Reference model: lamp lit/waiting/off, counted in edges since the switch went off.
  logic [3:0] pat [NUM_MODES] = '{4'b0011, 4'b0110, 4'b1100};
  bit m_on, m_wait, m_prev;
  int m_elapsed, m_mode, m_last;

  task automatic model_edge(input logic sw, input logic mem, input logic rst);
    bit rise, fall;
    if (!rst) begin
      m_on = 0; m_wait = 0; m_prev = 0; m_elapsed = 0; m_mode = 0; m_last = 0;
    end else begin
      rise = sw && !m_prev;
      fall = !sw && m_prev;
      if (m_on) begin
        if (fall) begin
          m_on = 0; m_wait = 1; m_elapsed = 0;
        end
      end else if (m_wait) begin
        m_elapsed++;
        if (rise) begin
          m_on = 1; m_wait = 0; m_mode = (m_mode + 1) % NUM_MODES;
        end else if (m_elapsed == WINDOW) begin
          m_wait = 0; m_last = m_mode;
        end
      end else if (rise) begin
        m_on = 1; m_mode = mem ? m_last : 0;
      end
      m_prev = sw;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic sw, input logic mem, input logic rst);
    sw_in  = sw;
    mem_en = mem;
    rst_n  = rst;
    @(posedge clk);
    model_edge(sw, mem, rst);
    #1;
  endtask

  typedef struct {
    logic       sw;
    logic       mem;
    logic       rst;
    logic [3:0] led;
    logic       on;
    logic [1:0] mode;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic sw, input logic mem, input logic rst,
                     input logic [3:0] e_led, input logic e_on, input logic [1:0] e_mode);
    vec_t v;
    v.sw = sw; v.mem = mem; v.rst = rst; v.led = e_led; v.on = e_on; v.mode = e_mode;
    vecs.push_back(v);
  endtask

  task automatic add_off(input int n, input logic mem, input logic [1:0] mode);
    for (int i = 0; i < n; i++) add(1'b0, mem, 1'b1, 4'b0000, 1'b0, mode);
  endtask

  task automatic add_on(input logic mem, input logic [1:0] mode);
    add(1'b1, mem, 1'b1, pat[mode], 1'b1, mode);
  endtask

  initial begin
    // Reset, then power on at mode 0.
    add(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0);
    add(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0);
    add_on(1'b0, 2'd0);
    add_on(1'b0, 2'd0);
    // Three flicks, 5 cycles off each: 1, 2, wrap to 0.
    add_off(5, 1'b0, 2'd0); add_on(1'b0, 2'd1);
    add_off(5, 1'b0, 2'd1); add_on(1'b0, 2'd2);
    add_off(5, 1'b0, 2'd2); add_on(1'b0, 2'd0);
    // Rise sampled at E0+12 still advances.
    add_off(WINDOW, 1'b0, 2'd0); add_on(1'b0, 2'd1);
    // Rise at E0+13 is a fresh power-on at mode 0.
    add_off(WINDOW + 1, 1'b0, 2'd1); add_on(1'b0, 2'd0);
    // Memory: reach mode 2, time out, resume mode 2.
    add_off(5, 1'b1, 2'd0); add_on(1'b1, 2'd1);
    add_off(5, 1'b1, 2'd1); add_on(1'b1, 2'd2);
    add_off(WINDOW + 2, 1'b1, 2'd2); add_on(1'b1, 2'd2);
    // Same with memory disabled: back to mode 0.
    add_off(WINDOW + 2, 1'b0, 2'd2); add_on(1'b0, 2'd0);
    // Reset mid-wait at mode 1 clears last_mode.
    add_off(5, 1'b0, 2'd0); add_on(1'b0, 2'd1);
    add_off(3, 1'b0, 2'd1);
    add(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0);
    add(1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0);
    add_on(1'b1, 2'd0);
    // Switch held on through reset release.
    add_off(2, 1'b0, 2'd0);
    add(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0);
    add(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0);
    add_on(1'b0, 2'd0);
    add_on(1'b0, 2'd0);

    foreach (vecs[i]) begin
      apply(vecs[i].sw, vecs[i].mem, vecs[i].rst);
      check($sformatf("vec%0d LED", i), 32'(led), 32'(vecs[i].led));
      check($sformatf("vec%0d lamp_on", i), 32'(lamp_on), 32'(vecs[i].on));
      check($sformatf("vec%0d mode_idx", i), 32'(mode_idx), 32'(vecs[i].mode));
    end

    // Randomized switch runs around the window length, with occasional resets.
    begin
      logic lvl;
      logic mem;
      logic rst;
      int   len;
      int   n;
      lvl = 1'b0;
      n = 0;
      apply(1'b0, 1'b0, 1'b0);
      for (int r = 0; r < 220; r++) begin
        lvl = ~lvl;
        len = $urandom_range(1, WINDOW + 4);
        mem = 1'($urandom_range(0, 1));
        for (int k = 0; k < len; k++) begin
          rst = ($urandom_range(0, 149) != 0);
          apply(lvl, mem, rst);
          check($sformatf("rnd%0d LED", n), 32'(led), m_on ? 32'(pat[m_mode]) : 32'd0);
          check($sformatf("rnd%0d lamp_on", n), 32'(lamp_on), 32'(m_on));
          check($sformatf("rnd%0d mode_idx", n), 32'(mode_idx), 32'(m_mode));
          n++;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lamp_mode_ctrl.md
# lamp_mode_ctrl

Parametrised wall-switch lamp controller: a single on/off switch selects among NUM_MODES LED colour patterns. An off-on flick within the wait window advances to the next mode (wrapping). Staying off past the window turns the lamp off. An optional memory mode resumes the last-used pattern instead of mode 0. Sits between the debounced switch detector and the LED driver pins.

## Interface
- NUM_MODES, 3, number of colour modes (≥2)
- LED_W, 4, LED output width
- PATTERNS, 12'hC63, flattened pattern table; mode k = PATTERNS[k*LED_W +: LED_W] (default: mode0 4'b0011, mode1 4'b0110, mode2 4'b1100)
- TICK_DIV, 5000, Sys_CLK cycles per timeout tick (≥2)
- WAIT_TICKS, 10000, ticks in the wait window (≥1)
- Sys_CLK  in  1  system clock; the only clock
- Sys_RST  in  1  reset; synchronous, active-low
- sw_in  in  1  debounced switch level (1 = on), synchronous to Sys_CLK
- mem_en  in  1  1 = resume last mode at power-on from IDLE
- LED  out  LED_W  registered lamp pattern
- mode_idx  out  max(1,$clog2(NUM_MODES))  registered current mode index
- lamp_on  out  1  registered; 1 only in ON

## Operation
- Edge detect: sw_q <= sw_in; rise = sw_in & ~sw_q; fall = ~sw_in & sw_q. sw_q resets to 0.
- States: IDLE, ON, WAIT.
- IDLE: LED=0, lamp_on=0. On rise -> ON with mode = mem_en ? last_mode : 0.
- ON: LED=PATTERNS[mode], lamp_on=1. On fall -> WAIT; prescaler and wait_cnt cleared.
- WAIT: LED=0, lamp_on=0. Prescaler counts 0..TICK_DIV-1; wait_cnt increments when prescaler = TICK_DIV-1.
  - On rise -> ON with mode = (mode == NUM_MODES-1) ? 0 : mode+1.
  - Otherwise, when the window expires -> IDLE, and last_mode <= mode.
  - Rise and expiry on the same edge: rise wins. Mode advances; last_mode is not updated.
- mode_idx holds its value through WAIT and IDLE; it shows the active or most recent mode.
- last_mode is updated only on timeout and is cleared by reset.
- Counters are sized to hold TICK_DIV-1 and WAIT_TICKS; no overflow is possible.
- Default in state decode: unreachable encodings -> IDLE with LED=0.
- Reset (Sys_RST=0 sampled at any edge, any state, including mid-WAIT):
  - state=IDLE, LED=0, lamp_on=0, mode_idx=0, last_mode=0.
  - sw_q=0, prescaler=0, wait_cnt=0.

## Timing
- All outputs are registered and update on the same edge as the state.
- Latency: sw_in first sampled at its new level on edge N -> state and outputs change after edge N (1 cycle).
- sw_in high when reset releases: rise is detected at the first non-reset edge -> ON.
- Wait window: WAIT entered at edge E0.
  - A rise sampled at any edge E0+1 … E0+WAIT_TICKS*TICK_DIV (inclusive) advances the mode.
  - With no rise, the state becomes IDLE at edge E0+WAIT_TICKS*TICK_DIV.
  - A rise at any later edge is an IDLE power-on.
- Default timing: window = 10000 × 5000 cycles (1 s at 50 MHz).

## Test plan
All scenarios use TICK_DIV=4, WAIT_TICKS=3, default PATTERNS, so the window is 12 cycles.
- Reset with sw_in=0 -> LED=0, lamp_on=0, mode_idx=0. Then sw_in=1 -> one cycle later LED=4'b0011, lamp_on=1, mode_idx=0.
- Three off-on flicks, each off for 5 cycles -> LED steps 4'b0110, 4'b1100, then wraps to 4'b0011; mode_idx steps 1, 2, 0. LED=0 while off.
- Off with the rise sampled at edge E0+12 -> advance to mode 1 (rise wins). Repeat with the rise at E0+13 and mem_en=0 -> IDLE at E0+12, then ON with mode 0, LED=4'b0011.
- mem_en=1: reach mode 2, stay off ≥12 cycles (IDLE), switch on -> LED=4'b1100, mode_idx=2. Same sequence with mem_en=0 -> LED=4'b0011.
- In WAIT at mode 1, assert Sys_RST=0 for one edge -> LED=0, mode_idx=0, lamp_on=0. Then mem_en=1, sw_in rises -> LED=4'b0011 (last_mode cleared).
- Hold sw_in=1 through reset release -> ON with LED=4'b0011 one cycle after the first non-reset edge.
